pong_ball_engine: RTL and testbench

- Game-logic stage upstream of the VGA renderer and the 7-segment score display.
- Once per video frame it advances the ball, bounces it off the top and bottom walls and off both paddles, and detects misses.
- It keeps both scores and runs the serve and game-over sequencing.
- Outputs are registered ball position, scores and game state; the renderer draws from them and seg_display_output consumes the scores.

---
 rtl/pong_ball_engine.sv | 166 ++++++++++++++++
 tb/tb_pong_ball_engine.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pong_ball_engine.sv
// Pong game-logic stage: once per frame_tick it moves the ball, bounces it off
// walls and paddles, scores misses and sequences serve / play / game-over.
module pong_ball_engine #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int BALL_SIZE    = 25,
  parameter int PADDLE_W     = 10,
  parameter int PADDLE_H     = 150,
  parameter int PADDLE_L_X   = 40,
  parameter int PADDLE_R_X   = 600,
  parameter int BALL_INI_X   = 269,
  parameter int BALL_INI_Y   = 189,
  parameter int BALL_SPEED   = 4,
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       pixel_clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [9:0] paddle_L_y,
  input  logic [9:0] paddle_R_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] score_one,
  output logic [3:0] score_two,
  output logic [1:0] game_state,
  output logic       point_pulse,
  output logic [1:0] winner
);
  typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, GAME_OVER = 2'd3} state_e;
  typedef logic signed [12:0] pos_t;
  typedef logic signed [10:0] vel_t;

  localparam int CW = $clog2(SERVE_FRAMES + 1);
  localparam pos_t ZERO     = '0;
  localparam pos_t L_FACE   = pos_t'(PADDLE_L_X + PADDLE_W);
  localparam pos_t R_FACE   = pos_t'(PADDLE_R_X);
  localparam pos_t X_STOP_R = pos_t'(PADDLE_R_X - BALL_SIZE);
  localparam pos_t BSZ      = pos_t'(BALL_SIZE);
  localparam pos_t PH       = pos_t'(PADDLE_H);
  localparam pos_t RIGHT    = pos_t'(SCREEN_W);
  localparam pos_t Y_MAX    = pos_t'(SCREEN_H - BALL_SIZE);
  localparam vel_t V_POS    = vel_t'(BALL_SPEED);
  localparam vel_t V_NEG    = vel_t'(-BALL_SPEED);
  localparam logic [9:0] INI_X = 10'(BALL_INI_X);
  localparam logic [9:0] INI_Y = 10'(BALL_INI_Y);
  localparam logic [3:0] WIN   = 4'(WIN_SCORE);
  localparam logic [CW-1:0] SF = CW'(SERVE_FRAMES);

  state_e        state_q;
  logic [9:0]    x_q, y_q;
  vel_t          vx_q, vy_q;
  logic [3:0]    s1_q, s2_q;
  logic          pulse_q;
  logic [1:0]    win_q;
  logic [CW-1:0] cnt_q;

  // Positions are widened to signed 13 bits so a step past 0 goes negative.
  pos_t x_s, nx, ny, pl_s, pr_s;
  logic hit_l, hit_r, miss_l, miss_r;
  logic [3:0] s1_inc, s2_inc;
  logic [CW-1:0] cnt_inc;

  assign x_s  = $signed({3'b000, x_q});
  assign nx   = x_s + pos_t'(vx_q);
  assign ny   = $signed({3'b000, y_q}) + pos_t'(vy_q);
  assign pl_s = $signed({3'b000, paddle_L_y});
  assign pr_s = $signed({3'b000, paddle_R_y});

  // Face-side tests: the ball must start on the near side of the paddle face.
  assign hit_l = vx_q[10] && (x_s >= L_FACE) && (nx <= L_FACE)
              && (ny < pl_s + PH) && (ny + BSZ > pl_s);
  assign hit_r = !vx_q[10] && (vx_q != V_POS - V_POS) && (x_s + BSZ <= R_FACE)
              && (nx + BSZ >= R_FACE) && (ny < pr_s + PH) && (ny + BSZ > pr_s);
  assign miss_l = (nx <= ZERO);
  assign miss_r = (nx + BSZ >= RIGHT);

  assign s1_inc  = (s1_q >= WIN) ? s1_q : s1_q + 4'd1;
  assign s2_inc  = (s2_q >= WIN) ? s2_q : s2_q + 4'd1;
  assign cnt_inc = cnt_q + CW'(1);

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      x_q     <= INI_X;
      y_q     <= INI_Y;
      vx_q    <= V_POS;
      vy_q    <= V_POS;
      s1_q    <= '0;
      s2_q    <= '0;
      pulse_q <= 1'b0;
      win_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q <= SERVE;
          cnt_q   <= '0;
        end
        SERVE: if (frame_tick) begin
          cnt_q <= cnt_inc;
          if (cnt_inc == SF) state_q <= PLAY;
        end
        PLAY: if (frame_tick) begin
          if (ny <= ZERO) begin
            y_q  <= '0;
            vy_q <= V_POS;
          end else if (ny >= Y_MAX) begin
            y_q  <= Y_MAX[9:0];
            vy_q <= V_NEG;
          end else begin
            y_q  <= ny[9:0];
          end
          if (hit_l) begin
            x_q  <= L_FACE[9:0];
            vx_q <= V_POS;
          end else if (hit_r) begin
            x_q  <= X_STOP_R[9:0];
            vx_q <= V_NEG;
          end else if (miss_l || miss_r) begin
            // Re-serve toward the loser; the y write here overrides the wall update.
            pulse_q <= 1'b1;
            x_q     <= INI_X;
            y_q     <= INI_Y;
            vx_q    <= miss_l ? V_NEG : V_POS;
            cnt_q   <= '0;
            state_q <= SERVE;
            if (miss_l) begin
              s2_q <= s2_inc;
              if (s2_inc == WIN) begin
                state_q <= GAME_OVER;
                win_q   <= 2'd2;
              end
            end else begin
              s1_q <= s1_inc;
              if (s1_inc == WIN) begin
                state_q <= GAME_OVER;
                win_q   <= 2'd1;
              end
            end
          end else begin
            x_q <= nx[9:0];
          end
        end
        GAME_OVER: if (start) begin
          s1_q    <= '0;
          s2_q    <= '0;
          win_q   <= 2'd0;
          vx_q    <= V_POS;
          cnt_q   <= '0;
          state_q <= SERVE;
        end
      endcase
    end
  end

  assign ball_x      = x_q;
  assign ball_y      = y_q;
  assign score_one   = s1_q;
  assign score_two   = s2_q;
  assign game_state  = state_q;
  assign point_pulse = pulse_q;
  assign winner      = win_q;
endmodule

// File: tb/tb_pong_ball_engine.sv
// Bench for pong_ball_engine: frame-level game model compared every cycle,
// plus hand-computed positions/scores at key frames of several rallies.
module tb_pong_ball_engine;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ft = 1'b0;
  logic       st = 1'b0;
  logic [9:0] pl = 10'd0;
  logic [9:0] pr = 10'd0;
  logic [9:0] ball_x, ball_y;
  logic [3:0] score_one, score_two;
  logic [1:0] game_state, winner;
  logic       point_pulse;

  int checks = 0;
  int failures = 0;

  pong_ball_engine dut (
    .pixel_clk(clk), .reset_n(rst_n), .frame_tick(ft), .start(st),
    .paddle_L_y(pl), .paddle_R_y(pr),
    .ball_x(ball_x), .ball_y(ball_y), .score_one(score_one), .score_two(score_two),
    .game_state(game_state), .point_pulse(point_pulse), .winner(winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st, x, y, vx, vy, s1, s2, cnt, pulse, win;
  } mdl_t;

  function automatic mdl_t reset_m();
    mdl_t r;
    r.st = 0; r.x = 269; r.y = 189; r.vx = 4; r.vy = 4;
    r.s1 = 0; r.s2 = 0; r.cnt = 0; r.pulse = 0; r.win = 0;
    return r;
  endfunction

  // One clock of game behaviour written straight from the rules with integers.
  function automatic mdl_t step(mdl_t m, bit tick, bit sp, int lp, int rp);
    mdl_t r = m;
    int nx, ny, sc;
    r.pulse = 0;
    if (m.st == 0) begin
      if (sp) begin r.st = 1; r.cnt = 0; end
    end else if (m.st == 1) begin
      if (tick) begin r.cnt = m.cnt + 1; if (r.cnt == 60) r.st = 2; end
    end else if (m.st == 3) begin
      if (sp) begin r.s1 = 0; r.s2 = 0; r.win = 0; r.vx = 4; r.st = 1; r.cnt = 0; end
    end else if (tick) begin
      nx = m.x + m.vx;
      ny = m.y + m.vy;
      if (ny <= 0) begin r.y = 0; r.vy = 4; end
      else if (ny >= 480 - 25) begin r.y = 455; r.vy = -4; end
      else r.y = ny;
      if (m.vx < 0 && m.x >= 50 && nx <= 50 && ny < lp + 150 && ny + 25 > lp) begin
        r.x = 50; r.vx = 4;
      end else if (m.vx > 0 && m.x + 25 <= 600 && nx + 25 >= 600 && ny < rp + 150 && ny + 25 > rp) begin
        r.x = 575; r.vx = -4;
      end else if (nx <= 0 || nx + 25 >= 640) begin
        r.pulse = 1; r.x = 269; r.y = 189; r.cnt = 0; r.st = 1;
        if (nx <= 0) begin
          r.vx = -4;
          sc = (m.s2 < 9) ? m.s2 + 1 : 9;
          r.s2 = sc;
          if (sc == 9) begin r.st = 3; r.win = 2; end
        end else begin
          r.vx = 4;
          sc = (m.s1 < 9) ? m.s1 + 1 : 9;
          r.s1 = sc;
          if (sc == 9) begin r.st = 3; r.win = 1; end
        end
      end else r.x = nx;
    end
    return r;
  endfunction

  mdl_t m;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) m <= reset_m();
    else        m <= step(m, ft, st, int'(pl), int'(pr));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_ball_x", int'(ball_x), m.x);
    chk("cyc_ball_y", int'(ball_y), m.y);
    chk("cyc_score_one", int'(score_one), m.s1);
    chk("cyc_score_two", int'(score_two), m.s2);
    chk("cyc_state", int'(game_state), m.st);
    chk("cyc_pulse", int'(point_pulse), m.pulse);
    chk("cyc_winner", int'(winner), m.win);
  end

  task automatic tick();
    repeat (2) @(negedge clk);
    ft = 1'b1;
    @(negedge clk);
    ft = 1'b0;
  endtask

  task automatic pulse_start(input bit with_tick);
    @(negedge clk);
    st = 1'b1; ft = with_tick;
    @(negedge clk);
    st = 1'b0; ft = 1'b0;
  endtask

  task automatic chk_ball(input string nm, input int ex, input int ey);
    chk({nm, "_x"}, int'(ball_x), ex);
    chk({nm, "_y"}, int'(ball_y), ey);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk_ball("reset_ball", 269, 189);
    chk("reset_state", int'(game_state), 0);
    chk("reset_scores", int'({score_one, score_two}), 0);
    chk("reset_pulse", int'(point_pulse), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    repeat (3) tick();
    chk_ball("idle_ball", 269, 189);
    chk("idle_state", int'(game_state), 0);

    pulse_start(1'b0);
    chk("serve_state", int'(game_state), 1);
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (i == 10) pulse_start(1'b0);
      if (i == 59) chk("serve_59_state", int'(game_state), 1);
    end
    chk("play_entry_state", int'(game_state), 2);
    chk_ball("play_entry_ball", 269, 189);

    // Rally A: right bounce, bottom/top wall bounces, left bounce, then miss left.
    pl = 10'd100; pr = 10'd300;
    for (int t = 1; t <= 485; t++) begin
      if (t == 211) begin pl = 10'd700; pr = 10'd200; end
      tick();
      case (t)
        1:   chk_ball("a_t1", 273, 193);
        66:  chk("a_t66_y", int'(ball_y), 453);
        67:  chk("a_t67_y", int'(ball_y), 455);
        68:  chk("a_t68_y", int'(ball_y), 451);
        77:  chk("a_t77_x", int'(ball_x), 575);
        78:  chk("a_t78_x", int'(ball_x), 571);
        208: chk("a_t208_x", int'(ball_x), 51);
        209: chk_ball("a_t209_lbounce", 50, 112);
        210: chk("a_t210_x", int'(ball_x), 54);
        341: chk_ball("a_t341_rbounce", 575, 271);
        485: begin
          chk("a_missl_score_two", int'(score_two), 1);
          chk("a_missl_pulse", int'(point_pulse), 1);
          chk("a_missl_state", int'(game_state), 1);
          chk_ball("a_missl_ball", 269, 189);
          @(negedge clk);
          chk("a_missl_pulse_end", int'(point_pulse), 0);
        end
        default: ;
      endcase
    end
    repeat (60) tick();
    tick();
    chk("a_reserve_left_x", int'(ball_x), 265);

    // Asynchronous reset in the middle of play, with a frame_tick while held.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_ball("async_rst_ball", 269, 189);
    chk("async_rst_score_two", int'(score_two), 0);
    chk("async_rst_state", int'(game_state), 0);
    @(negedge clk) ft = 1'b1;
    @(negedge clk) ft = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    // Rally B: no right-paddle overlap, miss right at frame 87.
    pulse_start(1'b0);
    repeat (60) tick();
    pl = 10'd700; pr = 10'd0;
    for (int t = 1; t <= 87; t++) begin
      tick();
      if (t == 77) chk("b_t77_nobounce_x", int'(ball_x), 577);
      if (t == 86) chk("b_t86_x", int'(ball_x), 613);
    end
    chk("b_missr_score_one", int'(score_one), 1);
    chk("b_missr_pulse", int'(point_pulse), 1);
    chk("b_missr_state", int'(game_state), 1);
    chk_ball("b_missr_ball", 269, 189);
    @(negedge clk);
    chk("b_missr_pulse_end", int'(point_pulse), 0);

    pr = 10'd700;
    for (int g = 2; g <= 9; g++) begin
      repeat (60) tick();
      tick();
      chk("serve_right_x", int'(ball_x), 273);
      repeat (86) tick();
      chk("rally_score_one", int'(score_one), g);
    end
    chk("over_state", int'(game_state), 3);
    chk("over_winner", int'(winner), 1);
    chk("over_score_two", int'(score_two), 0);
    repeat (3) tick();
    chk("over_hold_state", int'(game_state), 3);
    chk("over_hold_score", int'(score_one), 9);

    pulse_start(1'b1);
    chk("restart_state", int'(game_state), 1);
    chk("restart_score_one", int'(score_one), 0);
    chk("restart_winner", int'(winner), 0);
    chk_ball("restart_ball", 269, 189);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete t=%0t", $time);
    $fatal(1);
  end
endmodule
